rr_arbiter4: RTL

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with a hold timeout.
//
// A grant is made from IDLE one edge after a request is seen. It is held until
// the holder signals done, the holder drops its request, or the grant has been
// held for HOLD_MAX cycles. When the grant is revoked because HOLD_MAX ran out,
// timeout pulses for one cycle. Every release is followed by exactly one IDLE
// cycle before the next grant. The search for the next holder starts just
// after the most recent holder, so no continuous requester is starved.
//
// Handshake: a requester raises req[i] and keeps it high while it wants the
// resource. It owns the resource in each cycle in which gnt[i] is high. It
// ends ownership by pulsing done or by dropping req[i]. done is ignored while
// gnt_valid is low.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-high reset
//   req[3:0]    in   request lines, bit i = requester i
//   done        in   holder completion strobe
//   gnt[3:0]    out  one-hot grant (registered)
//   gnt_idx     out  binary index of holder, 0 when idle (registered)
//   gnt_valid   out  high while a grant is active (registered)
//   timeout     out  one-cycle pulse after a HOLD_MAX revocation
//   o_dbg_state out  FSM state (0 = IDLE, 1 = GRANT)
module rr_arbiter4 #(
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout,
  output logic       o_dbg_state
);

  localparam logic [7:0] HOLD_MAX_C = HOLD_MAX[7:0];

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [1:0] r_last, w_last_nxt;

  logic [1:0] w_sel;
  logic [1:0] w_cand;
  logic       w_found;
  logic       w_expired;
  logic       w_release;

  // Round-robin pick. Walk from last+4 down to last+1 so the closest
  // requester after r_last overwrites the others.
  always_comb begin
    w_sel   = 2'b00;
    w_cand  = 2'b00;
    w_found = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_last + 2'(k);
      if (req[w_cand]) begin
        w_sel   = w_cand;
        w_found = 1'b1;
      end
    end
  end

  assign w_expired = (r_hold == HOLD_MAX_C);
  assign w_release = done | ~req[r_idx] | w_expired;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    w_last_nxt    = r_last;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = 4'b0001 << w_sel;
          w_idx_nxt   = w_sel;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_sel;
          w_hold_nxt  = 8'd1;
        end
      end
      ST_GRANT: begin
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = 4'b0000;
          w_idx_nxt     = 2'b00;
          w_valid_nxt   = 1'b0;
          w_hold_nxt    = 8'd0;
          // done or a dropped request wins over expiry: no timeout pulse.
          w_timeout_nxt = w_expired & ~done & req[r_idx];
        end else if (r_hold != 8'hFF) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_idx_nxt   = 2'b00;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gnt     <= 4'b0000;
      r_idx     <= 2'b00;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= 8'd0;
      r_last    <= 2'b11;  // first search starts at requester 0
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
      r_hold    <= w_hold_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign gnt_idx     = r_idx;
  assign gnt_valid   = r_valid;
  assign timeout     = r_timeout;
  assign o_dbg_state = r_state;

endmodule
